// File: rtl/dcache_pkg.sv
// Shared geometry, FSM state type and address slicing for the direct-mapped data cache.
// The optional statistics counters are enabled by the DCACHE_STATS_EN macro.
package dcache_pkg;

  localparam int NUM_BLOCKS      = 8;
  localparam int WORDS_PER_BLOCK = 4;

  localparam int IDX_W   = $clog2(NUM_BLOCKS);
  localparam int OFF_W   = $clog2(WORDS_PER_BLOCK);
  localparam int TAG_W   = 30 - IDX_W - OFF_W;
  localparam int LINE_W  = 32 * WORDS_PER_BLOCK;
  localparam int MADDR_W = 30 - OFF_W;

  typedef enum logic [1:0] {
    IDLE,
    WBACK,
    ALLOC
  } state_e;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [IDX_W-1:0] idx;
    logic [OFF_W-1:0] off;
  } addr_fields_t;

  function automatic addr_fields_t split_addr(input logic [29:0] addr);
    return addr_fields_t'(addr);
  endfunction

endpackage

// File: rtl/dcache_if.sv
// Core-side and memory-side bundles of the data cache.
// For the core bus the cache is the slave; for the memory bus it is the master.
interface dcache_proc_if;
  logic        proc_read;
  logic        proc_write;
  logic [29:0] proc_addr;
  logic [31:0] proc_wdata;
  logic [31:0] proc_rdata;
  logic        proc_stall;

  modport master (output proc_read, proc_write, proc_addr, proc_wdata,
                  input  proc_rdata, proc_stall);
  modport slave  (input  proc_read, proc_write, proc_addr, proc_wdata,
                  output proc_rdata, proc_stall);
endinterface

interface dcache_mem_if;
  import dcache_pkg::*;

  logic               mem_read;
  logic               mem_write;
  logic [MADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0]  mem_wdata;
  logic [LINE_W-1:0]  mem_rdata;
  logic               mem_ready;

  modport master (output mem_read, mem_write, mem_addr, mem_wdata,
                  input  mem_rdata, mem_ready);
  modport slave  (input  mem_read, mem_write, mem_addr, mem_wdata,
                  output mem_rdata, mem_ready);
endinterface

// File: rtl/dcache_line_store.sv
// Valid/dirty/tag/data storage for the cache: one combinational read port and one write
// port that performs either a full-line fill (clean) or a single-word merge (dirty).
module dcache_line_store
  import dcache_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [IDX_W-1:0]  idx,
  output logic              rd_valid,
  output logic              rd_dirty,
  output logic [TAG_W-1:0]  rd_tag,
  output logic [LINE_W-1:0] rd_line,
  input  logic              fill_en,
  input  logic [TAG_W-1:0]  fill_tag,
  input  logic [LINE_W-1:0] fill_line,
  input  logic              word_en,
  input  logic [OFF_W-1:0]  word_off,
  input  logic [31:0]       word_data
);

  logic [NUM_BLOCKS-1:0] valid_q, valid_d;
  logic [NUM_BLOCKS-1:0] dirty_q, dirty_d;
  logic [TAG_W-1:0]      tag_mem  [NUM_BLOCKS];
  logic [LINE_W-1:0]     data_mem [NUM_BLOCKS];

  // NOTE: every variable written in always_comb takes a default first, otherwise a latch is inferred.
  always_comb begin
    valid_d = valid_q;
    dirty_d = dirty_q;
    if (fill_en) begin
      valid_d[idx] = 1'b1;
      dirty_d[idx] = 1'b0;
    end else if (word_en) begin
      dirty_d[idx] = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
  end

  // NOTE: tag/data arrays are deliberately not reset; valid bits alone make stale contents unreachable.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_mem[idx]  <= fill_tag;
      data_mem[idx] <= fill_line;
    end else if (word_en) begin
      data_mem[idx][{word_off, 5'd0} +: 32] <= word_data;
    end
  end

  assign rd_valid = valid_q[idx];
  assign rd_dirty = dirty_q[idx];
  assign rd_tag   = tag_mem[idx];
  assign rd_line  = data_mem[idx];

endmodule

// File: rtl/dcache_direct_mapped.sv
// Direct-mapped write-back, write-allocate data cache: FSM, hit compare and bus muxing.
// Define DCACHE_STATS_EN to add saturating stat_hits/stat_misses counters.
module dcache_direct_mapped
  import dcache_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  dcache_proc_if.slave proc,
  dcache_mem_if.master mem
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]  stat_hits,
  output logic [31:0]  stat_misses
`endif
);

  state_e             state_q, state_d;
  addr_fields_t       req;
  logic               req_active;
  logic               hit;
  logic               rd_valid, rd_dirty;
  logic [TAG_W-1:0]   rd_tag;
  logic [LINE_W-1:0]  rd_line;
  logic               fill_en, word_en;
  logic               proc_stall;
  logic [31:0]        proc_rdata;
  logic               mem_read, mem_write;
  logic [MADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0]  mem_wdata;

  assign req        = split_addr(proc.proc_addr);
  assign req_active = proc.proc_read | proc.proc_write;
  assign hit        = rd_valid && (rd_tag == req.tag);

  dcache_line_store u_line_store (
    .clk       (clk),
    .rst       (rst),
    .idx       (req.idx),
    .rd_valid  (rd_valid),
    .rd_dirty  (rd_dirty),
    .rd_tag    (rd_tag),
    .rd_line   (rd_line),
    .fill_en   (fill_en),
    .fill_tag  (req.tag),
    .fill_line (mem.mem_rdata),
    .word_en   (word_en),
    .word_off  (req.off),
    .word_data (proc.proc_wdata)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Everything is gated by rst so an abort drops requests in the reset cycle itself.
  always_comb begin
    state_d    = state_q;
    proc_stall = 1'b0;
    proc_rdata = '0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    fill_en    = 1'b0;
    word_en    = 1'b0;
    if (!rst) begin
      unique case (state_q)
        IDLE: begin
          if (req_active) begin
            if (hit) begin
              word_en = proc.proc_write;
              if (proc.proc_read && !proc.proc_write)
                proc_rdata = rd_line[{req.off, 5'd0} +: 32];
            end else begin
              proc_stall = 1'b1;
              state_d    = (rd_valid && rd_dirty) ? WBACK : ALLOC;
            end
          end
        end
        WBACK: begin
          proc_stall = 1'b1;
          mem_write  = 1'b1;
          mem_addr   = {rd_tag, req.idx};
          mem_wdata  = rd_line;
          if (mem.mem_ready) state_d = ALLOC;
        end
        ALLOC: begin
          proc_stall = 1'b1;
          mem_read   = 1'b1;
          mem_addr   = {req.tag, req.idx};
          if (mem.mem_ready) begin
            fill_en = 1'b1;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign proc.proc_stall = proc_stall;
  assign proc.proc_rdata = proc_rdata;
  assign mem.mem_read    = mem_read;
  assign mem.mem_write   = mem_write;
  assign mem.mem_addr    = mem_addr;
  assign mem.mem_wdata   = mem_wdata;

`ifdef DCACHE_STATS_EN
  logic [31:0] hits_q, hits_d;
  logic [31:0] misses_q, misses_d;
  logic        fill_done_q;
  logic        hit_cycle, miss_start;

  // The replayed request right after a fill is part of the miss, not a fresh hit.
  assign hit_cycle  = !rst && (state_q == IDLE) && req_active && hit && !fill_done_q;
  assign miss_start = !rst && (state_q == IDLE) && req_active && !hit;

  always_comb begin
    hits_d   = hits_q;
    misses_d = misses_q;
    if (hit_cycle && (hits_q != 32'hFFFF_FFFF))    hits_d   = hits_q + 32'd1;
    if (miss_start && (misses_q != 32'hFFFF_FFFF)) misses_d = misses_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hits_q      <= '0;
      misses_q    <= '0;
      fill_done_q <= 1'b0;
    end else begin
      hits_q      <= hits_d;
      misses_q    <= misses_d;
      fill_done_q <= fill_en;
    end
  end

  assign stat_hits   = hits_q;
  assign stat_misses = misses_q;
`endif

endmodule

// File: tb/tb_dcache_direct_mapped.sv
// Directed self-checking bench for dcache_direct_mapped: reset, miss/fill, write hit,
// dirty eviction, reset mid-miss and (with DCACHE_STATS_EN) the statistics counters.
module tb_dcache_direct_mapped;
  import dcache_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  dcache_proc_if proc_bus ();
  dcache_mem_if  mem_bus ();

`ifdef DCACHE_STATS_EN
  logic [31:0] stat_hits;
  logic [31:0] stat_misses;
`endif

  dcache_direct_mapped dut (
    .clk  (clk),
    .rst  (rst),
    .proc (proc_bus),
    .mem  (mem_bus)
`ifdef DCACHE_STATS_EN
    ,
    .stat_hits   (stat_hits),
    .stat_misses (stat_misses)
`endif
  );

  always #5 clk = ~clk;

  // Advance one clock and land 1ns after the edge, away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    proc_bus.proc_read  = 1'b1;
    proc_bus.proc_write = 1'b0;
    proc_bus.proc_addr  = 30'h10;
    proc_bus.proc_wdata = '0;
    mem_bus.mem_ready   = 1'b0;
    mem_bus.mem_rdata   = '0;
    step();
    step();
    checks++; if (proc_bus.proc_stall !== 1'b0) begin failures++; $display("FAIL reset_stall: got %b want 0", proc_bus.proc_stall); end
    checks++; if (mem_bus.mem_read !== 1'b0) begin failures++; $display("FAIL reset_mem_read: got %b want 0", mem_bus.mem_read); end
    checks++; if (mem_bus.mem_write !== 1'b0) begin failures++; $display("FAIL reset_mem_write: got %b want 0", mem_bus.mem_write); end
    checks++; if (mem_bus.mem_addr !== 28'h0) begin failures++; $display("FAIL reset_mem_addr: got %h want 0", mem_bus.mem_addr); end
    checks++; if (proc_bus.proc_rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata: got %h want 0", proc_bus.proc_rdata); end
  endtask

  task automatic test_read_miss();
    rst = 1'b0;
    proc_bus.proc_read = 1'b1;
    proc_bus.proc_addr = 30'h10;
    #1;
    checks++; if (proc_bus.proc_stall !== 1'b1) begin failures++; $display("FAIL miss_stall_same_cycle: got %b want 1", proc_bus.proc_stall); end
    checks++; if (mem_bus.mem_read !== 1'b0) begin failures++; $display("FAIL miss_idle_no_mem_read: got %b want 0", mem_bus.mem_read); end
    step();
    checks++; if (mem_bus.mem_read !== 1'b1) begin failures++; $display("FAIL alloc_mem_read: got %b want 1", mem_bus.mem_read); end
    checks++; if (mem_bus.mem_write !== 1'b0) begin failures++; $display("FAIL alloc_clean_no_wback: got %b want 0", mem_bus.mem_write); end
    checks++; if (mem_bus.mem_addr !== 28'h4) begin failures++; $display("FAIL alloc_mem_addr: got %h want 0000004", mem_bus.mem_addr); end
  endtask

  task automatic test_fill();
    step();
    checks++; if (mem_bus.mem_read !== 1'b1) begin failures++; $display("FAIL alloc_hold_mem_read: got %b want 1", mem_bus.mem_read); end
    step();
    mem_bus.mem_rdata = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'hDEAD_BEEF};
    mem_bus.mem_ready = 1'b1;
    #1;
    checks++; if (proc_bus.proc_stall !== 1'b1) begin failures++; $display("FAIL fill_stall_on_ready: got %b want 1", proc_bus.proc_stall); end
    step();
    mem_bus.mem_ready = 1'b0;
    #1;
    checks++; if (proc_bus.proc_stall !== 1'b0) begin failures++; $display("FAIL post_fill_stall: got %b want 0", proc_bus.proc_stall); end
    checks++; if (proc_bus.proc_rdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL post_fill_rdata: got %h want deadbeef", proc_bus.proc_rdata); end
    checks++; if (mem_bus.mem_read !== 1'b0) begin failures++; $display("FAIL post_fill_mem_read_drop: got %b want 0", mem_bus.mem_read); end
    step();
    checks++; if (proc_bus.proc_stall !== 1'b0) begin failures++; $display("FAIL reread_stall: got %b want 0", proc_bus.proc_stall); end
    checks++; if (proc_bus.proc_rdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL reread_rdata: got %h want deadbeef", proc_bus.proc_rdata); end
    step();
    // A stray mem_ready with no transfer outstanding must change nothing.
    proc_bus.proc_read = 1'b0;
    mem_bus.mem_ready  = 1'b1;
    #1;
    checks++; if (proc_bus.proc_stall !== 1'b0) begin failures++; $display("FAIL idle_ready_stall: got %b want 0", proc_bus.proc_stall); end
    step();
    mem_bus.mem_ready = 1'b0;
    #1;
    checks++; if ((mem_bus.mem_read | mem_bus.mem_write) !== 1'b0) begin failures++; $display("FAIL idle_ready_ignored: got rd=%b wr=%b want 0", mem_bus.mem_read, mem_bus.mem_write); end
  endtask

  task automatic test_write_hit();
    proc_bus.proc_write = 1'b1;
    proc_bus.proc_addr  = 30'h11;
    proc_bus.proc_wdata = 32'h1234_5678;
    #1;
    checks++; if (proc_bus.proc_stall !== 1'b0) begin failures++; $display("FAIL write_hit_stall: got %b want 0", proc_bus.proc_stall); end
    checks++; if (mem_bus.mem_write !== 1'b0) begin failures++; $display("FAIL write_hit_no_mem: got %b want 0", mem_bus.mem_write); end
    step();
    proc_bus.proc_write = 1'b0;
    proc_bus.proc_read  = 1'b1;
    #1;
    checks++; if (proc_bus.proc_rdata !== 32'h1234_5678) begin failures++; $display("FAIL write_hit_readback: got %h want 12345678", proc_bus.proc_rdata); end
    checks++; if (proc_bus.proc_stall !== 1'b0) begin failures++; $display("FAIL readback_stall: got %b want 0", proc_bus.proc_stall); end
    checks++; if (mem_bus.mem_read !== 1'b0) begin failures++; $display("FAIL readback_no_mem: got %b want 0", mem_bus.mem_read); end
    step();
  endtask

  task automatic test_evict();
    proc_bus.proc_addr = 30'h90;
    #1;
    checks++; if (proc_bus.proc_stall !== 1'b1) begin failures++; $display("FAIL evict_stall: got %b want 1", proc_bus.proc_stall); end
    step();
    checks++; if (mem_bus.mem_write !== 1'b1) begin failures++; $display("FAIL wback_mem_write: got %b want 1", mem_bus.mem_write); end
    checks++; if (mem_bus.mem_read !== 1'b0) begin failures++; $display("FAIL wback_no_mem_read: got %b want 0", mem_bus.mem_read); end
    checks++; if (mem_bus.mem_addr !== 28'h4) begin failures++; $display("FAIL wback_mem_addr: got %h want 0000004", mem_bus.mem_addr); end
    checks++; if (mem_bus.mem_wdata[63:32] !== 32'h1234_5678) begin failures++; $display("FAIL wback_word1: got %h want 12345678", mem_bus.mem_wdata[63:32]); end
    checks++; if (mem_bus.mem_wdata[31:0] !== 32'hDEAD_BEEF) begin failures++; $display("FAIL wback_word0: got %h want deadbeef", mem_bus.mem_wdata[31:0]); end
    mem_bus.mem_ready = 1'b1;
    step();
    mem_bus.mem_ready = 1'b0;
    #1;
    checks++; if (mem_bus.mem_read !== 1'b1) begin failures++; $display("FAIL evict_alloc_read: got %b want 1", mem_bus.mem_read); end
    checks++; if (mem_bus.mem_write !== 1'b0) begin failures++; $display("FAIL evict_write_drop: got %b want 0", mem_bus.mem_write); end
    checks++; if (mem_bus.mem_addr !== 28'h24) begin failures++; $display("FAIL evict_alloc_addr: got %h want 0000024", mem_bus.mem_addr); end
    mem_bus.mem_rdata = {32'h7777_7777, 32'h6666_6666, 32'h5555_5555, 32'hCAFE_F00D};
    mem_bus.mem_ready = 1'b1;
    step();
    mem_bus.mem_ready = 1'b0;
    #1;
    checks++; if (proc_bus.proc_rdata !== 32'hCAFE_F00D) begin failures++; $display("FAIL evict_fill_rdata: got %h want cafef00d", proc_bus.proc_rdata); end
    checks++; if (proc_bus.proc_stall !== 1'b0) begin failures++; $display("FAIL evict_fill_stall: got %b want 0", proc_bus.proc_stall); end
    step();
    proc_bus.proc_read = 1'b0;
`ifdef DCACHE_STATS_EN
    checks++; if (stat_misses !== 32'd2) begin failures++; $display("FAIL stat_misses: got %0d want 2", stat_misses); end
    checks++; if (stat_hits !== 32'd3) begin failures++; $display("FAIL stat_hits: got %0d want 3", stat_hits); end
`endif
  endtask

  task automatic test_reset_mid_miss();
    proc_bus.proc_read = 1'b1;
    proc_bus.proc_addr = 30'h10;
    #1;
    checks++; if (proc_bus.proc_stall !== 1'b1) begin failures++; $display("FAIL wrap_miss_stall: got %b want 1", proc_bus.proc_stall); end
    step();
    checks++; if (mem_bus.mem_write !== 1'b0) begin failures++; $display("FAIL clean_victim_no_wback: got %b want 0", mem_bus.mem_write); end
    checks++; if (mem_bus.mem_read !== 1'b1) begin failures++; $display("FAIL clean_victim_alloc: got %b want 1", mem_bus.mem_read); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    checks++; if (mem_bus.mem_read !== 1'b0) begin failures++; $display("FAIL abort_mem_read_drop: got %b want 0", mem_bus.mem_read); end
    checks++; if (proc_bus.proc_stall !== 1'b1) begin failures++; $display("FAIL abort_reissue_miss: got %b want 1", proc_bus.proc_stall); end
`ifdef DCACHE_STATS_EN
    checks++; if (stat_hits !== 32'd0) begin failures++; $display("FAIL stat_hits_reset: got %0d want 0", stat_hits); end
`endif
    step();
    checks++; if (mem_bus.mem_addr !== 28'h4) begin failures++; $display("FAIL reissue_alloc_addr: got %h want 0000004", mem_bus.mem_addr); end
    mem_bus.mem_rdata = {32'h0, 32'h0, 32'h0, 32'hA5A5_A5A5};
    mem_bus.mem_ready = 1'b1;
    step();
    mem_bus.mem_ready = 1'b0;
    #1;
    checks++; if (proc_bus.proc_rdata !== 32'hA5A5_A5A5) begin failures++; $display("FAIL reissue_fill_rdata: got %h want a5a5a5a5", proc_bus.proc_rdata); end
    step();
    proc_bus.proc_addr = 30'h90;
    step();
    checks++; if (mem_bus.mem_addr !== 28'h24) begin failures++; $display("FAIL wrap_evict_addr: got %h want 0000024", mem_bus.mem_addr); end
    checks++; if (mem_bus.mem_write !== 1'b0) begin failures++; $display("FAIL wrap_clean_no_wback: got %b want 0", mem_bus.mem_write); end
    rst = 1'b1;
    proc_bus.proc_read = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_read_miss();
    test_fill();
    test_write_hit();
    test_evict();
    test_reset_mid_miss();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
